// File: rtl/int2float_pipe.sv
// Integer to small-float converter, 3 register stages (sign/magnitude, leading-one, normalise/round/saturate).
// Latency 3 cycles, 1/cycle throughput; each stage loads when empty or advancing, so out_ready stalls back to in_ready combinationally.
module int2float_pipe #(
   parameter int IN_W   = 11,
   parameter int EXP_W  = 3,
   parameter int MAN_W  = 4,
   parameter int SIGNED = 0,
   parameter int RND    = 0,
   localparam int OUT_W = SIGNED + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] y,
   output logic             out_inexact,
   output logic             out_sat
);
   localparam int PW  = $clog2(IN_W);
   localparam int EW  = PW + EXP_W + 2;
   localparam int NW  = IN_W + 2;
   localparam int MW1 = MAN_W + 1;
   localparam int FW  = 1 + EXP_W + MAN_W;

   logic             s1_vld_q, s2_vld_q, s3_vld_q;
   logic             s1_ld, s2_ld, s3_ld, in_acc;
   logic             s1_sign_q, s2_sign_q;
   logic [IN_W-1:0]  s1_mag_q, s2_mag_q;
   logic [PW-1:0]    s2_pos_q;
   logic [OUT_W-1:0] y_q;
   logic             inexact_q, sat_q;

   logic             sign_d;
   logic [IN_W-1:0]  mag_d;
   logic [PW-1:0]    pos_d;
   logic [OUT_W-1:0] y_d;
   logic             inexact_d, sat_d;

   logic [PW-1:0]    lz_sh;
   logic [NW-1:0]    norm;
   logic [MAN_W-1:0] man_t, man_f;
   logic [MW1-1:0]   man_r;
   logic [EW-1:0]    exp_r;
   logic [EXP_W-1:0] exp_f;
   logic             guard, sticky, rnd_up;
   logic [FW-1:0]    y_full;
   logic             lint_unused;

   // A stage may load when it is empty or its occupant moves on this cycle.
   assign s3_ld    = !s3_vld_q || out_ready;
   assign s2_ld    = !s2_vld_q || s3_ld;
   assign s1_ld    = !s1_vld_q || s2_ld;
   assign in_ready = s1_ld;
   assign in_acc   = in_valid && in_ready;

   assign sign_d = (SIGNED != 0) && x[IN_W-1];
   assign mag_d  = sign_d ? (~x + IN_W'(1)) : x;

   always_comb begin
      pos_d = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (s1_mag_q[i]) pos_d = PW'(i);
      end
   end

   // Two zero bits are appended so guard and sticky exist even when MAN_W = IN_W-1.
   always_comb begin
      lz_sh     = PW'(IN_W - 1) - s2_pos_q;
      norm      = {s2_mag_q, 2'b00} << lz_sh;
      man_t     = norm[IN_W -: MAN_W];
      guard     = norm[IN_W-MAN_W];
      sticky    = |norm[IN_W-MAN_W-1:0];
      rnd_up    = (RND != 0) && guard && (sticky || man_t[0]);
      man_r     = {1'b0, man_t} + MW1'(rnd_up);
      exp_r     = EW'(s2_pos_q) - EW'(MAN_W - 1) + EW'(man_r[MAN_W]);
      exp_f     = '0;
      man_f     = '0;
      inexact_d = 1'b0;
      sat_d     = 1'b0;
      if (s2_pos_q < PW'(MAN_W)) begin
         man_f = s2_mag_q[MAN_W-1:0];
      end else if (exp_r > EW'((1 << EXP_W) - 1)) begin
         exp_f     = '1;
         man_f     = '1;
         inexact_d = 1'b1;
         sat_d     = 1'b1;
      end else begin
         exp_f     = exp_r[EXP_W-1:0];
         man_f     = man_r[MAN_W-1:0];
         inexact_d = guard || sticky;
      end
   end

   assign y_full      = {s2_sign_q, exp_f, man_f};
   assign y_d         = y_full[OUT_W-1:0];
   assign lint_unused = ^{y_full, norm[NW-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s3_vld_q  <= 1'b0;
         s1_sign_q <= 1'b0;
         s2_sign_q <= 1'b0;
         s1_mag_q  <= '0;
         s2_mag_q  <= '0;
         s2_pos_q  <= '0;
         y_q       <= '0;
         inexact_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         if (s1_ld) s1_vld_q <= in_valid;
         if (in_acc) begin
            s1_sign_q <= sign_d;
            s1_mag_q  <= mag_d;
         end
         if (s2_ld) s2_vld_q <= s1_vld_q;
         if (s2_ld && s1_vld_q) begin
            s2_sign_q <= s1_sign_q;
            s2_mag_q  <= s1_mag_q;
            s2_pos_q  <= pos_d;
         end
         if (s3_ld) s3_vld_q <= s2_vld_q;
         if (s3_ld && s2_vld_q) begin
            y_q       <= y_d;
            inexact_q <= inexact_d;
            sat_q     <= sat_d;
         end
      end
   end

   assign out_valid   = s3_vld_q;
   assign y           = y_q;
   assign out_inexact = inexact_q;
   assign out_sat     = sat_q;
endmodule

// File: tb/tb_int2float_pipe.sv
// Scoreboard bench: truncating, round-to-even and signed converters share one handshake.
module tb_int2float_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [10:0] x;

   logic       in_ready_t, out_valid_t, out_inexact_t, out_sat_t;
   logic       in_ready_r, out_valid_r, out_inexact_r, out_sat_r;
   logic       in_ready_s, out_valid_s, out_inexact_s, out_sat_s;
   logic [6:0] y_t, y_r;
   logic [7:0] y_s;

   typedef struct {
      logic [9:0] e;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t q_t[$], q_r[$], q_s[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;
   int   n_out[3];
   bit   lat_chk = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0), .RND(0)) u_trunc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .x(x),
      .out_valid(out_valid_t), .out_ready(out_ready), .y(y_t),
      .out_inexact(out_inexact_t), .out_sat(out_sat_t));

   int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0), .RND(1)) u_rne (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .x(x),
      .out_valid(out_valid_r), .out_ready(out_ready), .y(y_r),
      .out_inexact(out_inexact_r), .out_sat(out_sat_r));

   int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(1), .RND(0)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .x(x),
      .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s),
      .out_inexact(out_inexact_s), .out_sat(out_sat_s));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Reference: leading one found by magnitude comparison, rounding by remainder vs half-ulp.
   function automatic logic [9:0] model(input logic [10:0] xv, input bit sgn, input bit rnd);
      int m, p, sh, man, rem, half, e;
      bit s, inex, sat;
      s    = sgn && xv[10];
      m    = s ? (2048 - int'(xv)) : int'(xv);
      inex = 1'b0;
      sat  = 1'b0;
      e    = 0;
      man  = m;
      p    = 0;
      for (int i = 0; i < 11; i++) if (m >= (1 << i)) p = i;
      if (m != 0 && p >= 4) begin
         sh   = p - 4;
         man  = (m >> sh) - 16;
         rem  = m - ((m >> sh) << sh);
         e    = p - 3;
         inex = (rem != 0);
         if (rnd && sh > 0) begin
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (man % 2) == 1)) man++;
            if (man == 16) begin
               man = 0;
               e++;
            end
         end
         if (e > 7) begin
            e = 7; man = 15; sat = 1'b1; inex = 1'b1;
         end
      end
      return {sat, inex, s, e[2:0], man[3:0]};
   endfunction

   task automatic take(input int id, input logic [9:0] obs, input logic rdy);
      exp_t e;
      int   sz;
      sz = (id == 0) ? q_t.size() : (id == 1) ? q_r.size() : q_s.size();
      if (sz == 0) begin
         check_eq($sformatf("spurious_out%0d", id), 32'(sz), 1);
      end else begin
         case (id)
            0:       e = q_t[0];
            1:       e = q_r[0];
            default: e = q_s[0];
         endcase
         if (rdy) begin
            case (id)
               0:       q_t.pop_front();
               1:       q_r.pop_front();
               default: q_s.pop_front();
            endcase
            check_eq($sformatf("result%0d", id), 32'(obs), 32'(e.e));
            if (e.lat) check_eq($sformatf("latency%0d", id), 32'(cyc - e.cyc), 3);
            n_out[id]++;
         end else begin
            check_eq($sformatf("hold%0d", id), 32'(obs), 32'(e.e));
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t ne;
      if (!rst_n) begin
         q_t.delete();
         q_r.delete();
         q_s.delete();
      end else begin
         if (out_valid_t) take(0, {out_sat_t, out_inexact_t, 1'b0, y_t}, out_ready);
         if (out_valid_r) take(1, {out_sat_r, out_inexact_r, 1'b0, y_r}, out_ready);
         if (out_valid_s) take(2, {out_sat_s, out_inexact_s, y_s}, out_ready);
         if (in_valid && in_ready_t) begin
            ne.cyc = cyc;
            ne.lat = lat_chk;
            ne.e   = model(x, 1'b0, 1'b0);
            q_t.push_back(ne);
            ne.e   = model(x, 1'b0, 1'b1);
            q_r.push_back(ne);
            ne.e   = model(x, 1'b1, 1'b0);
            q_s.push_back(ne);
         end
      end
   end

   task automatic directed(input logic [10:0] v, input logic [7:0] ey_t, input logic [1:0] ef_t,
                           input logic [7:0] ey_r, input logic [1:0] ef_r, input logic [7:0] ey_s);
      int n;
      lat_chk  = 1'b1;
      in_valid = 1'b1;
      x        = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid_t && n < 8) begin
         @(negedge clk);
         n++;
      end
      check_eq($sformatf("dir_valid x=%0d", v), 32'(out_valid_t), 1);
      check_eq($sformatf("dir_y_trunc x=%0d", v), 32'(y_t), 32'(ey_t));
      check_eq($sformatf("dir_flags_trunc x=%0d", v), {30'b0, out_sat_t, out_inexact_t}, 32'(ef_t));
      check_eq($sformatf("dir_y_rne x=%0d", v), 32'(y_r), 32'(ey_r));
      check_eq($sformatf("dir_flags_rne x=%0d", v), {30'b0, out_sat_r, out_inexact_r}, 32'(ef_r));
      check_eq($sformatf("dir_y_signed x=%0d", v), 32'(y_s), 32'(ey_s));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, n0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      n_out     = '{0, 0, 0};

      repeat (3) @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid_t), 0);
      check_eq("rst_y", 32'(y_t), 0);
      check_eq("rst_inexact", 32'(out_inexact_t), 0);
      check_eq("rst_sat", 32'(out_sat_t), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_in_ready", 32'(in_ready_t), 1);
      @(posedge clk);
      #1 out_ready = 1'b1;

      directed(11'd0,    8'h00, 2'b00, 8'h00, 2'b00, 8'h00);
      directed(11'd13,   8'h0D, 2'b00, 8'h0D, 2'b00, 8'h0D);
      directed(11'd16,   8'h10, 2'b00, 8'h10, 2'b00, 8'h10);
      directed(11'd2047, 8'h7F, 2'b01, 8'h7F, 2'b11, 8'h81);
      directed(11'd63,   8'h2F, 2'b01, 8'h30, 2'b01, 8'h2F);
      directed(11'h7F0,  8'h7F, 2'b01, 8'h7F, 2'b11, 8'h90);
      directed(11'h400,  8'h70, 2'b00, 8'h70, 2'b00, 8'hF0);

      // Backpressure: output stalled for six cycles with input always offered.
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      n0        = n_out[0];
      acc       = 0;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         x        = 11'(100 + acc * 37);
         @(negedge clk);
         if (in_ready_t) acc++;
         @(posedge clk);
         #1;
      end
      check_eq("bp_accepted", 32'(acc), 3);
      @(negedge clk);
      check_eq("bp_in_ready_low", 32'(in_ready_t), 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      x = 11'd1500;
      @(negedge clk);
      check_eq("bp_accept_on_emit", 32'(in_ready_t), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      check_eq("bp_results_out", 32'(n_out[0] - n0), 4);
      check_eq("bp_queue_empty", 32'(q_t.size()), 0);

      // Streaming: 100 back-to-back random operands.
      lat_chk = 1'b1;
      n0      = n_out[0];
      acc     = 0;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         x        = 11'($urandom_range(0, 2047));
         @(negedge clk);
         if (in_ready_t) acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      check_eq("stream_accepted", 32'(acc), 100);
      check_eq("stream_results_out", 32'(n_out[0] - n0), 100);
      check_eq("stream_queue_empty", 32'(q_s.size()), 0);

      // Reset with two operands in flight, the first already presented at the output.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x         = 11'd5;
      @(posedge clk);
      #1 x = 11'd6;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mid_out_valid_before_rst", 32'(out_valid_t), 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 32'(out_valid_t), 0);
      check_eq("mid_rst_y", 32'(y_t), 0);
      check_eq("mid_rst_out_valid_signed", 32'(out_valid_s), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      n0 = n_out[0];
      repeat (8) @(posedge clk);
      #1;
      check_eq("mid_rst_no_results", 32'(n_out[0] - n0), 0);
      directed(11'd9, 8'h09, 2'b00, 8'h09, 2'b00, 8'h09);
      drain();
      check_eq("final_queue_empty", 32'(q_t.size() + q_r.size() + q_s.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/int2float_pipe.md
INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 11: integer input width, minimum 4.
REQ-002 SHALL have parameter EXP_W, default 3: exponent field width.
REQ-003 SHALL have parameter MAN_W, default 4: stored mantissa width, with MAN_W < IN_W.
REQ-004 SHALL have parameter SIGNED, default 0: 1 selects a two's-complement input and a sign bit in the output.
REQ-005 SHALL have parameter RND, default 0: 0 selects truncate, 1 selects round-to-nearest-even.
REQ-006 SHALL define OUT_W = SIGNED + EXP_W + MAN_W.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit: x is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts x this cycle.
REQ-011 SHALL have port x, input, IN_W bits: the integer operand.
REQ-012 SHALL have port out_valid, output, 1 bit: y and its flags are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts y.
REQ-014 SHALL have port y, output, OUT_W bits: {sign (if SIGNED), exp[EXP_W-1:0], man[MAN_W-1:0]}.
REQ-015 SHALL have port out_inexact, output, 1 bit: nonzero bits were discarded or rounded.
REQ-016 SHALL have port out_sat, output, 1 bit: the result was saturated.

Function
REQ-017 SHALL compute the magnitude m as x when SIGNED=0, and as |x| on IN_W bits when SIGNED=1, so that the most negative input gives m = 2^(IN_W-1); sign = x[IN_W-1].
REQ-018 SHALL encode m = 0 as exp = 0, man = 0, sign = 0, inexact = 0.
REQ-019 SHALL, with p the index of the leading one of m and p < MAN_W, produce exp = 0, man = m[MAN_W-1:0], exact.
REQ-020 SHALL, for p >= MAN_W, produce exp = p - MAN_W + 1 and man = m[p-1:p-MAN_W]; the hidden one is dropped and the discarded bits are m[p-MAN_W-1:0].
REQ-021 SHALL, when RND=1, round using guard bit = m[p-MAN_W-1] and sticky = OR of the lower bits; a tie rounds to even (man LSB).
REQ-022 SHALL, when rounding overflows the mantissa, set man = 0 and increment exp by 1.
REQ-023 SHALL, when the final exp exceeds 2^EXP_W - 1, output exp and man all ones with out_sat = 1 and out_inexact = 1.
REQ-024 SHALL set out_inexact = 1 whenever any discarded bit is nonzero, in both RND modes.
REQ-025 SHALL pipeline the conversion in 3 register stages: S1 captures sign and magnitude; S2 holds the leading-one position; S3 holds the normalised, rounded and saturated result driving the outputs.
REQ-026 SHALL have a latency of exactly 3 cycles from an accepted input to out_valid when there is no backpressure.
REQ-027 SHALL sustain throughput of 1 per cycle.
REQ-028 SHALL treat a transfer as in_valid & in_ready at input and out_valid & out_ready at output.
REQ-029 SHALL let each stage load when it is empty or when its contents advance in the same cycle.
REQ-030 SHALL drive in_ready = !S1_valid | S1_advances; in_ready is combinational from out_ready through the stage valids.
REQ-031 SHALL hold y, out_inexact and out_sat stable while out_valid = 1 and out_ready = 0.
REQ-032 SHALL never drop, duplicate or reorder results.
REQ-033 SHALL accept a new input in the same cycle that the full pipe emits a result with out_ready = 1.
REQ-034 SHALL ignore x when in_valid = 0 and leave stage contents unchanged.

Reset
REQ-035 SHALL, while rst_n = 0, clear all stage valids immediately.
REQ-036 SHALL drive out_valid = 0, y = 0, out_inexact = 0 and out_sat = 0 during reset.
REQ-037 SHALL drive in_ready = 1 after reset.
REQ-038 SHALL discard in-flight operands on reset; the first result after release comes only from an input accepted after release.

Verification (defaults IN_W=11, EXP_W=3, MAN_W=4, SIGNED=0, unless stated)
REQ-039 Bench SHALL check small values, RND=0: x = 0 -> y = 0x00; x = 13 -> y = 0x0D; x = 16 -> y = 0x10; all exact; each arrives 3 cycles after acceptance.
REQ-040 Bench SHALL check large and rounded values: RND=0, x = 2047 -> y = 0x7F, inexact = 1, sat = 0; RND=1, x = 63 -> y = 0x30 (tie rounds up to even, mantissa carries into exp); RND=1, x = 2047 -> y = 0x7F, sat = 1.
REQ-041 Bench SHALL check backpressure: in_valid held high with incrementing x and out_ready = 0 for 6 cycles -> exactly 3 inputs accepted, in_ready = 0 thereafter, y held stable; after release all results emerge in order with none lost.
REQ-042 Bench SHALL check streaming: out_ready = 1 and 100 back-to-back inputs -> 100 results in 100 consecutive cycles, starting at cycle 3.
REQ-043 Bench SHALL check SIGNED=1, OUT_W=8: x = -16 -> y = 0x90; x = -1024 -> y = 0xF0 (exp 7, man 0).
REQ-044 Bench SHALL check reset mid-operation: 2 operands in flight, then rst_n pulsed low for 1 cycle -> out_valid = 0 immediately and those 2 results never appear.
